// File: rtl/alu_regs_seq_if.sv
// ---------------------------------------------------------------------------
// alu_regs_seq_if
//   Bus bundle between the board switch/button logic (master) and the
//   sequenced ALU/register-file datapath (slave).
//
//   Command side (master -> slave):
//     Start      request one read/execute/write-back operation
//     R_Addr_A   source A register address
//     R_Addr_B   source B register address
//     W_Addr     destination register address
//     ALU_OP     4-bit operation code
//     Reg_Write  write result back at write-back
//     Ld_En      direct register load strobe
//     Ld_Addr    load address
//     Ld_Data    load data
//     Out_Sel    display source select (01=A, 10=B, 11=F, 00=idle pattern)
//   Status side (slave -> master):
//     Busy, Done, A, B, F, FR {ZF,CF,OF,SF}, Disp_Data
// ---------------------------------------------------------------------------
interface alu_regs_seq_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              Start;
  logic [ADDR_W-1:0] R_Addr_A;
  logic [ADDR_W-1:0] R_Addr_B;
  logic [ADDR_W-1:0] W_Addr;
  logic [3:0]        ALU_OP;
  logic              Reg_Write;
  logic              Ld_En;
  logic [ADDR_W-1:0] Ld_Addr;
  logic [DATA_W-1:0] Ld_Data;
  logic [1:0]        Out_Sel;

  logic              Busy;
  logic              Done;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [DATA_W-1:0] F;
  logic [3:0]        FR;
  logic [DATA_W-1:0] Disp_Data;

  modport master (
    output Start, R_Addr_A, R_Addr_B, W_Addr, ALU_OP, Reg_Write,
           Ld_En, Ld_Addr, Ld_Data, Out_Sel,
    input  Busy, Done, A, B, F, FR, Disp_Data
  );

  modport slave (
    input  Start, R_Addr_A, R_Addr_B, W_Addr, ALU_OP, Reg_Write,
           Ld_En, Ld_Addr, Ld_Data, Out_Sel,
    output Busy, Done, A, B, F, FR, Disp_Data
  );
endinterface

// File: rtl/alu_regs_seq.sv
// ---------------------------------------------------------------------------
// alu_regs_seq
//   Single-clock ALU + register file. One Start pulse walks the FSM through
//   IDLE -> READ -> EXEC -> WB -> DONE: READ captures operands A/B, EXEC
//   captures result F and flags FR, WB writes F back, DONE pulses Done.
//   In IDLE (and without Start) the load port writes registers directly.
//
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset
//     bus  alu_regs_seq_if.slave (command inputs, status/data outputs)
// ---------------------------------------------------------------------------
module alu_regs_seq #(
  parameter int          DATA_W       = 32,
  parameter int          ADDR_W       = 5,
  parameter bit          R0_ZERO      = 1'b1,
  parameter logic [31:0] IDLE_PATTERN = 32'hE0E0_E0E0
) (
  input  logic           clk,
  input  logic           rst,
  alu_regs_seq_if.slave  bus
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam int SH_W  = $clog2(DATA_W);
  localparam int MSB   = DATA_W - 1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_NOR = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0101;
  localparam logic [3:0] OP_SLT = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b0111;
  localparam logic [3:0] OP_SRL = 4'b1000;
  localparam logic [3:0] OP_SRA = 4'b1001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  // Operation fields captured on the Start edge so later input changes are inert.
  logic [ADDR_W-1:0] op_ra, op_rb, op_wa;
  logic [3:0]        op_alu;
  logic              op_we;

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] a_q, b_q, f_q;
  logic [3:0]        fr_q;

  logic              start_take;
  logic              load_take;
  logic              wb_take;
  logic              busy, done;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: state elements use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // a value unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_IDLE: if (bus.Start) state_nxt = S_READ;
      S_READ: begin busy = 1'b1; state_nxt = S_EXEC; end
      S_EXEC: begin busy = 1'b1; state_nxt = S_WB;   end
      S_WB:   begin busy = 1'b1; state_nxt = S_DONE; end
      S_DONE: begin done = 1'b1; state_nxt = S_IDLE; end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign start_take = (state == S_IDLE) && bus.Start;
  // Start has priority over a simultaneous load.
  assign load_take  = (state == S_IDLE) && !bus.Start && bus.Ld_En &&
                      !(R0_ZERO && (bus.Ld_Addr == '0));
  assign wb_take    = (state == S_WB) && op_we &&
                      !(R0_ZERO && (op_wa == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_ra  <= '0;
      op_rb  <= '0;
      op_wa  <= '0;
      op_alu <= '0;
      op_we  <= 1'b0;
    end else if (start_take) begin
      op_ra  <= bus.R_Addr_A;
      op_rb  <= bus.R_Addr_B;
      op_wa  <= bus.W_Addr;
      op_alu <= bus.ALU_OP;
      op_we  <= bus.Reg_Write;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file: load port in IDLE, write-back in WB (mutually exclusive).
  // ---------------------------------------------------------------------------
  // NOTE: the register file is required to clear on reset, so it is built
  // from resettable flops rather than a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (load_take) begin
      regs[bus.Ld_Addr] <= bus.Ld_Data;
    end else if (wb_take) begin
      regs[op_wa] <= f_q;
    end
  end

  logic [DATA_W-1:0] rd_a, rd_b;
  assign rd_a = (R0_ZERO && (op_ra == '0)) ? '0 : regs[op_ra];
  assign rd_b = (R0_ZERO && (op_rb == '0)) ? '0 : regs[op_rb];

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  logic [DATA_W:0]   sum, diff;
  logic [SH_W-1:0]   sh;
  logic [DATA_W-1:0] alu_f;
  logic              alu_cf, alu_of;

  always_comb begin
    sum    = {1'b0, a_q} + {1'b0, b_q};
    // Top bit of the widened difference is the unsigned borrow (A < B).
    diff   = {1'b0, a_q} - {1'b0, b_q};
    sh     = b_q[SH_W-1:0];
    alu_f  = '0;
    alu_cf = 1'b0;
    alu_of = 1'b0;
    case (op_alu)
      OP_AND: alu_f = a_q & b_q;
      OP_OR:  alu_f = a_q | b_q;
      OP_XOR: alu_f = a_q ^ b_q;
      OP_NOR: alu_f = ~(a_q | b_q);
      OP_ADD: begin
        alu_f  = sum[MSB:0];
        alu_cf = sum[DATA_W];
        alu_of = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        alu_f  = diff[MSB:0];
        alu_cf = diff[DATA_W];
        alu_of = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
      end
      OP_SLT: alu_f = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_SLL: alu_f = a_q << sh;
      OP_SRL: alu_f = a_q >> sh;
      OP_SRA: alu_f = $signed(a_q) >>> sh;
      default: alu_f = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      f_q  <= '0;
      fr_q <= '0;
    end else begin
      if (state == S_READ) begin
        a_q <= rd_a;
        b_q <= rd_b;
      end
      if (state == S_EXEC) begin
        f_q  <= alu_f;
        fr_q <= {(alu_f == '0), alu_cf, alu_of, alu_f[MSB]};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    case (bus.Out_Sel)
      2'b01:   bus.Disp_Data = a_q;
      2'b10:   bus.Disp_Data = b_q;
      2'b11:   bus.Disp_Data = f_q;
      default: bus.Disp_Data = DATA_W'(IDLE_PATTERN);
    endcase
  end

  assign bus.Busy = busy;
  assign bus.Done = done;
  assign bus.A    = a_q;
  assign bus.B    = b_q;
  assign bus.F    = f_q;
  assign bus.FR   = fr_q;

endmodule

// File: tb/tb_alu_regs_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_regs_seq
//   Directed bench for alu_regs_seq: a 32-bit instance (5-bit addresses) and
//   a 16-bit instance (3-bit addresses) sharing clk/rst. Inputs change and
//   outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_alu_regs_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_regs_seq_if #(.DATA_W(32), .ADDR_W(5)) bus32 ();
  alu_regs_seq_if #(.DATA_W(16), .ADDR_W(3)) bus16 ();

  alu_regs_seq #(.DATA_W(32), .ADDR_W(5), .R0_ZERO(1'b1),
                 .IDLE_PATTERN(32'hE0E0_E0E0)) u32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32.slave)
  );

  alu_regs_seq #(.DATA_W(16), .ADDR_W(3), .R0_ZERO(1'b1),
                 .IDLE_PATTERN(32'hE0E0_E0E0)) u16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16.slave)
  );

  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0101;
  localparam logic [3:0] OP_SLT = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b0111;
  localparam logic [3:0] OP_SRL = 4'b1000;
  localparam logic [3:0] OP_SRA = 4'b1001;

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load32(input logic [4:0] addr, input logic [31:0] data);
    bus32.Ld_En   = 1'b1;
    bus32.Ld_Addr = addr;
    bus32.Ld_Data = data;
    tick();
    bus32.Ld_En   = 1'b0;
  endtask

  task automatic load16(input logic [2:0] addr, input logic [15:0] data);
    bus16.Ld_En   = 1'b1;
    bus16.Ld_Addr = addr;
    bus16.Ld_Data = data;
    tick();
    bus16.Ld_En   = 1'b0;
  endtask

  // Single-cycle Start, bounded wait for Done, latency check, back to IDLE.
  task automatic op32(input string tag, input logic [4:0] ra, input logic [4:0] rb,
                      input logic [4:0] wa, input logic [3:0] op, input logic we);
    int lat;
    bus32.R_Addr_A  = ra;
    bus32.R_Addr_B  = rb;
    bus32.W_Addr    = wa;
    bus32.ALU_OP    = op;
    bus32.Reg_Write = we;
    bus32.Start     = 1'b1;
    tick();
    bus32.Start     = 1'b0;
    check({tag, " busy"}, 64'(bus32.Busy), 64'd1);
    lat = 1;
    while (!bus32.Done && lat < 10) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'd4);
    tick();
  endtask

  task automatic op16(input string tag, input logic [2:0] ra, input logic [2:0] rb,
                      input logic [2:0] wa, input logic [3:0] op, input logic we);
    int lat;
    bus16.R_Addr_A  = ra;
    bus16.R_Addr_B  = rb;
    bus16.W_Addr    = wa;
    bus16.ALU_OP    = op;
    bus16.Reg_Write = we;
    bus16.Start     = 1'b1;
    tick();
    bus16.Start     = 1'b0;
    lat = 1;
    while (!bus16.Done && lat < 10) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'd4);
    tick();
  endtask

  initial begin
    int lat;
    int dones;

    rst = 1'b1;
    bus32.Start = 1'b0; bus32.R_Addr_A = '0; bus32.R_Addr_B = '0;
    bus32.W_Addr = '0;  bus32.ALU_OP = '0;   bus32.Reg_Write = 1'b0;
    bus32.Ld_En = 1'b0; bus32.Ld_Addr = '0;  bus32.Ld_Data = '0;
    bus32.Out_Sel = 2'b00;
    bus16.Start = 1'b0; bus16.R_Addr_A = '0; bus16.R_Addr_B = '0;
    bus16.W_Addr = '0;  bus16.ALU_OP = '0;   bus16.Reg_Write = 1'b0;
    bus16.Ld_En = 1'b0; bus16.Ld_Addr = '0;  bus16.Ld_Data = '0;
    bus16.Out_Sel = 2'b00;

    tick();
    tick();
    check("reset busy", 64'(bus32.Busy), 64'd0);
    check("reset done", 64'(bus32.Done), 64'd0);
    check("reset F",    64'(bus32.F),    64'd0);
    check("reset FR",   64'(bus32.FR),   64'd0);
    check("reset disp", 64'(bus32.Disp_Data), 64'hE0E0_E0E0);
    rst = 1'b0;
    tick();

    // Signed overflow on ADD, result written to R3 and read back.
    load32(5'd1, 32'h7FFF_FFFF);
    load32(5'd2, 32'h0000_0001);
    op32("add ovf", 5'd1, 5'd2, 5'd3, OP_ADD, 1'b1);
    check("add ovf F",  64'(bus32.F),  64'h8000_0000);
    check("add ovf FR", 64'(bus32.FR), 64'b0011);
    op32("rd r3", 5'd3, 5'd0, 5'd0, OP_OR, 1'b0);
    check("rd r3 A", 64'(bus32.A), 64'h8000_0000);
    check("rd r3 F", 64'(bus32.F), 64'h8000_0000);

    // SUB: equal operands, then borrow.
    load32(5'd4, 32'd5);
    load32(5'd5, 32'd5);
    op32("sub eq", 5'd4, 5'd5, 5'd0, OP_SUB, 1'b0);
    check("sub eq F",  64'(bus32.F),  64'h0);
    check("sub eq FR", 64'(bus32.FR), 64'b1000);
    load32(5'd4, 32'd3);
    op32("sub brw", 5'd4, 5'd5, 5'd0, OP_SUB, 1'b0);
    check("sub brw F",  64'(bus32.F),  64'hFFFF_FFFE);
    check("sub brw FR", 64'(bus32.FR), 64'b0101);

    // Shifts and signed compare.
    load32(5'd6, 32'h8000_0000);
    load32(5'd7, 32'd4);
    op32("sra", 5'd6, 5'd7, 5'd0, OP_SRA, 1'b0);
    check("sra F", 64'(bus32.F), 64'hF800_0000);
    op32("srl", 5'd6, 5'd7, 5'd0, OP_SRL, 1'b0);
    check("srl F", 64'(bus32.F), 64'h0800_0000);
    op32("slt", 5'd6, 5'd7, 5'd0, OP_SLT, 1'b0);
    check("slt F",  64'(bus32.F),  64'h1);
    check("slt FR", 64'(bus32.FR), 64'b0000);
    op32("sll", 5'd7, 5'd7, 5'd0, OP_SLL, 1'b0);
    check("sll F", 64'(bus32.F), 64'h40);

    // Register 0 ignores write-back and loads.
    op32("add r0", 5'd1, 5'd2, 5'd0, OP_ADD, 1'b1);
    load32(5'd0, 32'hDEAD_BEEF);
    op32("rd r0", 5'd0, 5'd0, 5'd0, OP_OR, 1'b0);
    check("rd r0 A", 64'(bus32.A), 64'h0);
    check("rd r0 F", 64'(bus32.F), 64'h0);

    // Start and load pulsed while busy are dropped.
    bus32.R_Addr_A = 5'd1; bus32.R_Addr_B = 5'd2; bus32.W_Addr = 5'd0;
    bus32.ALU_OP = OP_ADD; bus32.Reg_Write = 1'b0;
    bus32.Start = 1'b1;
    tick();
    bus32.Start = 1'b0;
    tick();
    bus32.Start = 1'b1; bus32.Ld_En = 1'b1;
    bus32.Ld_Addr = 5'd8; bus32.Ld_Data = 32'h55;
    tick();
    bus32.Start = 1'b0; bus32.Ld_En = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus32.Done) dones++;
      tick();
    end
    check("busy start dones", 64'(dones), 64'd1);
    op32("rd r8", 5'd8, 5'd0, 5'd0, OP_OR, 1'b0);
    check("rd r8 A", 64'(bus32.A), 64'h0);

    // Single-cycle Start in the DONE cycle is ignored.
    bus32.Start = 1'b1;
    tick();
    bus32.Start = 1'b0;
    lat = 1;
    while (!bus32.Done && lat < 10) begin
      tick();
      lat++;
    end
    check("done pulse latency", 64'(lat), 64'd4);
    bus32.Start = 1'b1;
    tick();
    bus32.Start = 1'b0;
    check("done start ignored a", 64'(bus32.Busy), 64'd0);
    tick();
    check("done start ignored b", 64'(bus32.Busy), 64'd0);

    // Start held high re-triggers on the first IDLE cycle.
    bus32.Start = 1'b1;
    tick();
    lat = 1;
    while (!bus32.Done && lat < 10) begin
      tick();
      lat++;
    end
    check("held latency", 64'(lat), 64'd4);
    tick();
    check("held idle busy", 64'(bus32.Busy), 64'd0);
    tick();
    check("held retrigger busy", 64'(bus32.Busy), 64'd1);
    bus32.Start = 1'b0;
    lat = 1;
    while (!bus32.Done && lat < 10) begin
      tick();
      lat++;
    end
    check("retrigger latency", 64'(lat), 64'd4);
    tick();

    // Display mux.
    load32(5'd9,  32'd1);
    load32(5'd10, 32'd2);
    op32("disp add", 5'd9, 5'd10, 5'd11, OP_ADD, 1'b1);
    bus32.Out_Sel = 2'b00; #1 check("disp 00", 64'(bus32.Disp_Data), 64'hE0E0_E0E0);
    bus32.Out_Sel = 2'b01; #1 check("disp 01", 64'(bus32.Disp_Data), 64'h1);
    bus32.Out_Sel = 2'b10; #1 check("disp 10", 64'(bus32.Disp_Data), 64'h2);
    bus32.Out_Sel = 2'b11; #1 check("disp 11", 64'(bus32.Disp_Data), 64'h3);
    bus32.Out_Sel = 2'b00;
    tick();

    // 16-bit instance: wrap-around.
    load16(3'd1, 16'hFFFF);
    load16(3'd2, 16'h0001);
    op16("add16", 3'd1, 3'd2, 3'd3, OP_ADD, 1'b1);
    check("add16 F",  64'(bus16.F),  64'h0);
    check("add16 FR", 64'(bus16.FR), 64'b1100);
    check("disp16 00", 64'(bus16.Disp_Data), 64'hE0E0);

    // Reset asserted while in EXEC.
    bus32.R_Addr_A = 5'd9; bus32.R_Addr_B = 5'd10; bus32.W_Addr = 5'd12;
    bus32.ALU_OP = OP_ADD; bus32.Reg_Write = 1'b1;
    bus32.Start = 1'b1;
    tick();
    bus32.Start = 1'b0;
    tick();
    check("pre-rst exec busy", 64'(bus32.Busy), 64'd1);
    rst = 1'b1;
    #1;
    check("mid rst busy", 64'(bus32.Busy), 64'd0);
    check("mid rst done", 64'(bus32.Done), 64'd0);
    check("mid rst F",    64'(bus32.F),    64'd0);
    check("mid rst FR",   64'(bus32.FR),   64'd0);
    check("mid rst A",    64'(bus32.A),    64'd0);
    tick();
    rst = 1'b0;
    tick();
    op32("post rst", 5'd9, 5'd10, 5'd11, OP_ADD, 1'b0);
    check("post rst A", 64'(bus32.A), 64'h0);
    check("post rst B", 64'(bus32.B), 64'h0);
    op32("post rst r11", 5'd11, 5'd1, 5'd0, OP_OR, 1'b0);
    check("post rst r11 F", 64'(bus32.F), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
